serial_adder_ctrl: RTL and testbench

Bit-serial adder controller. It sequences a single one-bit FullAdder cell over a WIDTH-bit operand pair, one bit per clock, LSB first. The carry is held in a flip-flop between bits. A start/busy/done handshake lets the team reuse one full-adder cell for multi-bit additions, in place of a WIDTH-cell ripple chain.

---
 rtl/serial_adder_ctrl_pkg.sv | 12 +
 rtl/serial_adder_ctrl_fa.sv | 11 +
 rtl/serial_adder_ctrl.sv | 75 +++++++
 tb/tb_serial_adder_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: shared FSM state encodings and default operand width
`ifndef SERIAL_ADDER_CTRL_PKG_SV
`define SERIAL_ADDER_CTRL_PKG_SV
package serial_adder_ctrl_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage
`endif

// File: rtl/serial_adder_ctrl_fa.sv
// serial_adder_ctrl_fa: one-bit full-adder cell (a, b, cin -> s, cout)
module serial_adder_ctrl_fa (
  output logic s,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder over one full-adder cell (clk, rst, start, a, b, cin -> busy, done, sum, cout)
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_cout;
  serial_adder_ctrl_fa u_fa (
    .s    (fa_s),
    .cout (fa_cout),
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          a_sr  <= a;
          b_sr  <= b;
          carry <= cin;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= ST_RUN;
        end
        ST_RUN: begin
          carry <= fa_cout;
          s_sr  <= {fa_s, s_sr[WIDTH-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= {fa_s, s_sr[WIDTH-1:1]};
            cout  <= fa_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;
  int         n_cmp = 0;
  int         n_err = 0;
  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );
  always #5 clk = ~clk;
  task automatic launch(input logic [7:0] x, input logic [7:0] y, input logic c);
    a = x;
    b = y;
    cin = c;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done && cycles < 40);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done, cout, sum} !== 11'h0) begin
        n_err++;
        $display("FAIL reset[%0d]: got busy=%b done=%b cout=%b sum=%h expected all zero", i, busy, done, cout, sum);
      end
    end
  endtask
  task automatic test_nominal;
    launch(8'h5A, 8'h3C, 1'b0);
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== (j <= 8) || done !== (j == 9)) begin
        n_err++;
        $display("FAIL nominal_hs cycle k+%0d: got busy=%b done=%b expected busy=%b done=%b", j, busy, done, j <= 8, j == 9);
      end
    end
    n_cmp++;
    if (sum !== 8'h96 || cout !== 1'b0) begin
      n_err++;
      $display("FAIL nominal_result: got cout=%b sum=%h expected cout=0 sum=96", cout, sum);
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      n_cmp++;
      if (sum !== 8'h96 || cout !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL nominal_hold[%0d]: got done=%b cout=%b sum=%h expected done=0 cout=0 sum=96", j, done, cout, sum);
      end
    end
  endtask
  task automatic test_carry;
    logic [7:0] va [3] = '{8'hFF, 8'hFF, 8'h00};
    logic [7:0] vb [3] = '{8'h01, 8'h00, 8'h00};
    logic       vc [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] es [3] = '{8'h00, 8'h00, 8'h01};
    logic       ec [3] = '{1'b1, 1'b1, 1'b0};
    int         cyc;
    for (int i = 0; i < 3; i++) begin
      launch(va[i], vb[i], vc[i]);
      wait_done(cyc);
      n_cmp++;
      if (cyc !== 9 || sum !== es[i] || cout !== ec[i]) begin
        n_err++;
        $display("FAIL carry[%0d]: got lat=%0d cout=%b sum=%h expected lat=9 cout=%b sum=%h", i, cyc, cout, sum, ec[i], es[i]);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_ignored_start;
    int nd = 0;
    int at = 0;
    a = 8'h0F;
    b = 8'h01;
    cin = 1'b0;
    start = 1'b1;
    for (int e = 0; e < 14; e++) begin
      @(posedge clk);
      #1;
      if (e == 2) begin
        a = 8'h11;
        b = 8'h22;
      end
      if (e == 4) start = 1'b0;
      @(negedge clk);
      if (done) begin
        nd++;
        at = e + 1;
      end
    end
    n_cmp++;
    if (nd !== 1 || at !== 9) begin
      n_err++;
      $display("FAIL ignored_start_pulses: got count=%0d at=k+%0d expected count=1 at=k+9", nd, at);
    end
    n_cmp++;
    if (sum !== 8'h10 || cout !== 1'b0) begin
      n_err++;
      $display("FAIL ignored_start_result: got cout=%b sum=%h expected cout=0 sum=10", cout, sum);
    end
  endtask
  task automatic test_back_to_back;
    int nd = 0;
    int at [3] = '{0, 0, 0};
    a = 8'h80;
    b = 8'h80;
    cin = 1'b0;
    start = 1'b1;
    for (int e = 0; e < 29; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        if (nd < 3) at[nd] = e + 1;
        nd++;
        n_cmp++;
        if (sum !== 8'h00 || cout !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_result[%0d]: got cout=%b sum=%h expected cout=1 sum=00", nd, cout, sum);
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (nd !== 3 || at[0] !== 9 || at[1] !== 19 || at[2] !== 29) begin
      n_err++;
      $display("FAIL b2b_timing: got count=%0d at=%0d,%0d,%0d expected count=3 at=9,19,29", nd, at[0], at[1], at[2]);
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic test_reset_mid;
    int nd = 0;
    int cyc;
    a = 8'h5A;
    b = 8'h3C;
    cin = 1'b1;
    start = 1'b1;
    for (int e = 0; e < 14; e++) begin
      @(posedge clk);
      #1;
      if (e == 0) start = 1'b0;
      if (e == 3) rst = 1'b1;
      if (e == 4) rst = 1'b0;
      @(negedge clk);
      if (done) nd++;
      if (e >= 4) begin
        n_cmp++;
        if (busy !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
          n_err++;
          $display("FAIL reset_mid cycle k+%0d: got busy=%b cout=%b sum=%h expected busy=0 cout=0 sum=00", e + 1, busy, cout, sum);
        end
      end
    end
    n_cmp++;
    if (nd !== 0) begin
      n_err++;
      $display("FAIL reset_mid_done: got %0d done pulses expected 0", nd);
    end
    launch(8'h01, 8'h02, 1'b1);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 9 || sum !== 8'h04 || cout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_restart: got lat=%0d cout=%b sum=%h expected lat=9 cout=0 sum=04", cyc, cout, sum);
    end
  endtask
  initial begin
    test_reset;
    test_nominal;
    test_carry;
    test_ignored_start;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
